// File: rtl/gol_pkg.sv
// Shared constants, FSM state type and helpers for the Game-of-Life population counter.
package gol_pkg;

  localparam int unsigned ROWS  = 30;
  localparam int unsigned COLS  = 40;
  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned CNT_W = 11;
  localparam int unsigned BCD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CONV,
    DONE
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/grid_population_counter_bcd_double_dabble.sv
// Sequential binary-to-BCD converter: one double-dabble step per clk, CNT_W steps per conversion.
module bcd_double_dabble
  import gol_pkg::*;
#(
  parameter int unsigned CNT_W = gol_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] bin,
  output logic [15:0]      bcd,
  output logic             ready
);

  localparam int unsigned SH_W  = 16 + CNT_W;
  localparam int unsigned CTR_W = clog2(CNT_W + 1);

  logic [SH_W-1:0]  r_sh;
  logic [CTR_W-1:0] r_left;
  logic [SH_W-1:0]  w_src;
  logic [SH_W-1:0]  w_adj;
  logic [SH_W-1:0]  w_step;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // The load cycle already performs the first step, so CNT_W-1 steps remain afterwards.
  always_comb begin
    w_src  = load ? {16'h0000, bin} : r_sh;
    w_adj  = {adj3(w_src[SH_W-1  -: 4]), adj3(w_src[SH_W-5  -: 4]),
              adj3(w_src[SH_W-9  -: 4]), adj3(w_src[SH_W-13 -: 4]),
              w_src[CNT_W-1:0]};
    w_step = w_adj << 1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh   <= '0;
      r_left <= '0;
    end else if (load) begin
      r_sh   <= w_step;
      r_left <= CTR_W'(CNT_W - 1);
    end else if (r_left != '0) begin
      r_sh   <= w_step;
      r_left <= r_left - CTR_W'(1);
    end
  end

  assign bcd   = r_sh[SH_W-1 -: 16];
  assign ready = (r_left == '0);

endmodule

// File: rtl/grid_population_counter.sv
// Snapshot-and-scan live-cell counter with optional BCD output (enabled by GRID_POP_BCD_EN).
module grid_population_counter
  import gol_pkg::*;
#(
  parameter int unsigned ROWS  = gol_pkg::ROWS,
  parameter int unsigned COLS  = gol_pkg::COLS,
  parameter int unsigned CHUNK = gol_pkg::CHUNK,
  parameter int unsigned CNT_W = gol_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] grid,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     count,
  output logic [15:0]          bcd
);

  localparam int unsigned NCELL  = ROWS * COLS;
  localparam int unsigned NCHUNK = NCELL / CHUNK;
  localparam int unsigned IDX_W  = clog2(NCHUNK);
  localparam int unsigned SEL_W  = clog2(NCELL);

  state_t           r_state;
  state_t           w_state_next;
  logic [NCELL-1:0] r_snap;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_idx;
  logic [SEL_W-1:0] w_base;
  logic [CHUNK-1:0] w_chunk;
  logic [CHUNK-1:0] w_tmp;
  logic [CNT_W-1:0] w_pop;
  logic [CNT_W-1:0] w_sum;
  logic             w_last;

  always_comb begin
    w_base  = SEL_W'(r_idx) * SEL_W'(CHUNK);
    w_chunk = r_snap[w_base +: CHUNK];
    w_tmp   = w_chunk;
    w_pop   = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      w_pop = w_pop + CNT_W'(w_tmp[0]);
      w_tmp = w_tmp >> 1;
    end
    w_sum  = r_acc + w_pop;
    w_last = (r_idx == IDX_W'(NCHUNK - 1));
  end

`ifdef GRID_POP_BCD_EN
  logic        w_dd_load;
  logic        w_dd_ready;
  logic [15:0] w_dd_bcd;
  logic [15:0] r_bcd;

  // The converter loads the final sum combinationally in the last SCAN cycle.
  bcd_double_dabble #(
    .CNT_W(CNT_W)
  ) u_dd (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (w_dd_load),
    .bin    (w_sum),
    .bcd    (w_dd_bcd),
    .ready  (w_dd_ready)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start) w_state_next = SCAN;
`ifdef GRID_POP_BCD_EN
      SCAN: if (w_last) w_state_next = CONV;
      CONV: if (w_dd_ready) w_state_next = DONE;
`else
      SCAN: if (w_last) w_state_next = DONE;
`endif
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
`ifdef GRID_POP_BCD_EN
    w_dd_load = (r_state == SCAN) && w_last;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap  <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_snap <= grid;
          r_acc  <= '0;
          r_idx  <= '0;
        end
        SCAN: begin
          r_acc <= w_sum;
          r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
      if (w_state_next == DONE && r_state != DONE)
        r_count <= (r_state == SCAN) ? w_sum : r_acc;
    end
  end

`ifdef GRID_POP_BCD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_bcd <= '0;
    else if (w_state_next == DONE && r_state != DONE)
      r_bcd <= w_dd_bcd;
  end

  assign bcd = r_bcd;
`else
  assign bcd = '0;
`endif

  assign count = r_count;

endmodule

// File: tb/tb_grid_population_counter.sv
// Directed bench for grid_population_counter; adapts latency/BCD expectations to GRID_POP_BCD_EN.
module tb_grid_population_counter;
  import gol_pkg::*;

`ifdef GRID_POP_BCD_EN
  localparam int LAT    = 162;
  localparam bit BCD_ON = 1'b1;
`else
  localparam int LAT    = 151;
  localparam bit BCD_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [CELLS-1:0] grid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic [15:0]      bcd;

  int n_checks = 0;
  int n_errors = 0;
  logic [CNT_W-1:0] prev_count;
  logic [15:0]      prev_bcd;

  grid_population_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .CHUNK(CHUNK),
    .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .grid   (grid),
    .busy   (busy),
    .done   (done),
    .count  (count),
    .bcd    (bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CELLS-1:0] low_ones(input int n);
    logic [CELLS-1:0] g;
    g = '0;
    for (int i = 0; i < n; i++) g = {g[CELLS-2:0], 1'b1};
    return g;
  endfunction

  // Start pulse is sampled at edge 0; cycle c runs from edge c-1 to edge c, sampled mid-cycle.
  task automatic run_scan(input string tag, input logic [CELLS-1:0] g, input bit clr,
                          input int s_a, input int s_b, input int exp_cnt,
                          input logic [15:0] exp_bcd);
    int n_done;
    int done_at;
    int busy_err;
    int hold_err;
    n_done   = 0;
    done_at  = -1;
    busy_err = 0;
    hold_err = 0;
    grid = g;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (clr) grid = '0;
    for (int c = 1; c <= LAT + 8; c++) begin
      if (done === 1'b1) begin
        n_done++;
        done_at = c;
        if (n_done == 1) begin
          chk({tag, ".count"}, 32'(count), 32'(exp_cnt));
          chk({tag, ".bcd"}, 32'(bcd), BCD_ON ? 32'(exp_bcd) : 32'h0);
        end
      end
      if (busy !== (c <= LAT)) busy_err++;
      if (c < LAT && (count !== prev_count || bcd !== prev_bcd)) hold_err++;
      start = (c == s_a || c == s_b);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".ndone"}, 32'(n_done), 32'd1);
    chk({tag, ".done_at"}, 32'(done_at), 32'(LAT));
    chk({tag, ".busy_err"}, 32'(busy_err), 32'd0);
    chk({tag, ".hold_err"}, 32'(hold_err), 32'd0);
    prev_count = count;
    prev_bcd   = bcd;
  endtask

  initial begin
    int n_done;
    logic [CELLS-1:0] g;
    reset_n    = 1'b0;
    start      = 1'b0;
    grid       = '0;
    prev_count = '0;
    prev_bcd   = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.bcd", 32'(bcd), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_scan("zeros", '0, 1'b0, 0, 0, 0, 16'h0000);
    run_scan("ones", '1, 1'b0, 0, 0, 1200, 16'h1200);
    g = {1'b1, {(CELLS-1){1'b0}}};
    run_scan("bit1199", g, 1'b0, 0, 0, 1, 16'h0001);
    g = CELLS'(1);
    run_scan("bit0", g, 1'b0, 0, 0, 1, 16'h0001);
    run_scan("snap37", low_ones(37), 1'b1, 0, 0, 37, 16'h0037);
    run_scan("n999", low_ones(999), 1'b0, 0, 0, 999, 16'h0999);
    g = {(CELLS/2){2'b10}};
    run_scan("multistart", g, 1'b0, 5, LAT, 600, 16'h0600);
    run_scan("pre37", low_ones(37), 1'b0, 0, 0, 37, 16'h0037);

    grid = '1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (79) @(negedge clk);
    chk("abort.held", 32'(count), 32'd37);
    reset_n = 1'b0;
    #1;
    chk("abort.count", 32'(count), 32'd0);
    chk("abort.bcd", 32'(bcd), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("abort.nodone", 32'(n_done), 32'd0);
    chk("abort.idle_count", 32'(count), 32'd0);
    prev_count = '0;
    prev_bcd   = '0;
    run_scan("restart", '1, 1'b0, 0, 0, 1200, 16'h1200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
